seven_segment_reader: RTL and testbench
=======================================

# seven_segment_reader

Recovers hex nibbles from a multiplexed, active-high seven-segment display bus. This is the inverse of the team's hex-to-segment decoder. It synchronizes the segment and digit-enable lines and waits until the bus has been stable for a programmable number of clocks. It then decodes the pattern back to a 4-bit value and stores it per digit. It sits on the observation side of a display path (board-level self-check, logic-analyzer capture).

## Interface
- `NUM_DIGITS`, 4: number of multiplexed digits (1–8).
- `STABLE_CYCLES`, 4: consecutive unchanged synchronized samples required before capture (≥1).
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `seg` in 7: segment lines, active-high, `seg[0]`=a … `seg[6]`=g. Asynchronous to `clk`.
- `dig_en` in `NUM_DIGITS`: digit enables, active-high, expected one-hot. Asynchronous to `clk`.
- `clr` in 1: synchronous clear of all `digit_valid` and `digit_err` bits.
- `digits` out `4*NUM_DIGITS`: captured nibbles, digit i at `[4i+3:4i]`.
- `digit_valid` out `NUM_DIGITS`: digit i holds a successfully decoded value.
- `digit_err` out `NUM_DIGITS`: sticky; digit i last captured an undecodable pattern.
- `upd` out 1: one-cycle strobe on every capture.
- `upd_idx` out `$clog2(NUM_DIGITS)` (min 1): digit index of the capture.
- `upd_nibble` out 4: decoded value; 0 on error.
- `upd_err` out 1: capture pattern was not in the table.

## Operation
- Two-flop synchronizer on `{dig_en, seg}` produces a synchronized vector S. Reset value is 0.
- Stability counter `cnt` has width `$clog2(STABLE_CYCLES+1)`.
  - If S differs from its previous value, `cnt` clears to 0.
  - Otherwise `cnt` increments, saturating at `STABLE_CYCLES`.
- FSM states:
  - **WAIT**: go to HOLD when `cnt` reaches `STABLE_CYCLES` and S's `dig_en` field is exactly one-hot. Capture on that transition.
  - **HOLD**: no further captures. Return to WAIT on any change of S.
  - If `dig_en` is zero or multi-hot when stable, stay in WAIT with no capture. That pattern is blanking or ghosting.
- Decode table (hex value → `seg` pattern):
  - 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F, 4→0x66, 5→0x6D, 6→0x7D, 7→0x07
  - 8→0x7F, 9→0x6F, A→0x77, b→0x7C, C→0x39, d→0x5E, E→0x79, F→0x71
- On a valid capture into digit i:
  - `digits[i]` = decoded value, `digit_valid[i]` = 1, `digit_err[i]` = 0.
- On an invalid pattern (any code not in the table, including 0x00):
  - `digits[i]` is unchanged, `digit_valid[i]` = 0, `digit_err[i]` = 1.
- `clr` clears all valid and err bits. `digits` are not cleared.
  - If `clr` and a capture occur in the same cycle, `clr` applies to all digits and the capture then writes its own digit: capture wins for its index.
- Rescan behaviour:
  - A new capture for the same digit overwrites the previous result.
  - Repeated display scans of an identical digit re-capture only because `dig_en` changes between scans.

## Timing
- Reset (asynchronous, immediate) sets:
  - all outputs to 0;
  - synchronizer, S, and `cnt` to 0;
  - FSM to WAIT.
- Reset asserted mid-count or mid-HOLD aborts the operation; no `upd` is emitted.
- Latency: inputs first sampled at edge 1 and held constant → S updates at edge 2.
  - At edge 2+`STABLE_CYCLES`, `upd`, the `upd_*` fields, `digits`, `digit_valid` and `digit_err` all register together.
  - They are visible in the following cycle, i.e. `STABLE_CYCLES`+2 clocks after the input change.
- `upd` is high for exactly one cycle. The `upd_*` fields hold their values until the next capture.
- Input glitches shorter than `STABLE_CYCLES` synchronized samples produce no capture.
- With `STABLE_CYCLES`=1, a change held for one sample still captures.
- `cnt` saturates: there is no wrap-around, so no re-capture after long holds.

## Test plan
- **Reset values**: reset, hold `dig_en`=4'b0001, `seg`=0x5B → exactly one `upd`, 6 clocks after release (default parameters).
  - Then `upd_idx`=0, `upd_nibble`=2, `digits[3:0]`=2, `digit_valid`=4'b0001.
- **Round-trip vectors**: drive the patterns for 2, 5, 8, E (0x5B, 0x6D, 0x7F, 0x79) on digits 0–3 in turn.
  - `digits` = 16'hE852 and `digit_valid` = 4'hF.
  - Sweep all 16 table entries on one digit; each yields the matching nibble.
- **Invalid and blanking**: `seg`=0x00 on digit 1 → `upd_err`=1, `digit_err[1]`=1, `digits[7:4]` unchanged.
  - `dig_en`=4'b0011 or 4'b0000 held 20 clocks → no `upd`.
- **Glitch rejection**: toggle `seg[3]` every 3 clocks for 30 clocks → no `upd`.
  - Then hold steady → exactly one `upd`; holding 100 more clocks gives no second `upd`.
- **Clear collision**: assert `clr` in the same cycle as a capture on digit 2 (value 7).
  - Result: `digit_valid`=4'b0100, `digit_err`=0, `digits[11:8]`=7.
- **Reset mid-operation**: assert `rst` at `cnt`=2.
  - All outputs 0; after release the same held input captures exactly once at full latency.

Source files
------------

// File: rtl/seven_segment_reader.sv
// Seven-segment bus reader: synchronizes a multiplexed active-high display bus,
// waits for a stable pattern and decodes it back into per-digit hex nibbles.

module seven_segment_reader_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       cap,
    input  logic       cap_err,
    input  logic [3:0] cap_nibble,
    output logic [3:0] digit,
    output logic       valid,
    output logic       err
);
    logic [3:0] digit_q, digit_d;
    logic       valid_q, valid_d;
    logic       err_q,   err_d;

    always_comb begin
        digit_d = digit_q;
        valid_d = clr ? 1'b0 : valid_q;
        err_d   = clr ? 1'b0 : err_q;
        // A capture on this digit overrides a simultaneous clear
        if (cap) begin
            if (cap_err) begin
                valid_d = 1'b0;
                err_d   = 1'b1;
            end else begin
                digit_d = cap_nibble;
                valid_d = 1'b1;
                err_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            digit_q <= digit_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign digit = digit_q;
    assign valid = valid_q;
    assign err   = err_q;
endmodule

module seven_segment_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    input  logic                    clr,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    upd,
    output logic [IDX_W-1:0]        upd_idx,
    output logic [3:0]              upd_nibble,
    output logic                    upd_err
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int SW    = NUM_DIGITS + 7;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    typedef enum logic {ST_WAIT, ST_HOLD} state_t;

    // Returns {err, nibble}; err set for any pattern outside the hex table
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        case (p)
            7'h3F: seg_decode = 5'h00;
            7'h06: seg_decode = 5'h01;
            7'h5B: seg_decode = 5'h02;
            7'h4F: seg_decode = 5'h03;
            7'h66: seg_decode = 5'h04;
            7'h6D: seg_decode = 5'h05;
            7'h7D: seg_decode = 5'h06;
            7'h07: seg_decode = 5'h07;
            7'h7F: seg_decode = 5'h08;
            7'h6F: seg_decode = 5'h09;
            7'h77: seg_decode = 5'h0A;
            7'h7C: seg_decode = 5'h0B;
            7'h39: seg_decode = 5'h0C;
            7'h5E: seg_decode = 5'h0D;
            7'h79: seg_decode = 5'h0E;
            7'h71: seg_decode = 5'h0F;
            default: seg_decode = 5'h10;
        endcase
    endfunction

    logic [SW-1:0]         sync1_q, sync1_d;
    logic [SW-1:0]         s_q,     s_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    state_t                state_q, state_d;
    logic                  upd_q,        upd_d;
    logic [IDX_W-1:0]      upd_idx_q,    upd_idx_d;
    logic [3:0]            upd_nibble_q, upd_nibble_d;
    logic                  upd_err_q,    upd_err_d;

    logic [NUM_DIGITS-1:0] s_dig;
    logic [6:0]            s_seg;
    logic                  s_change;
    logic                  one_hot;
    logic                  cap;
    logic [4:0]            dec;
    logic [IDX_W-1:0]      enc_idx;

    assign s_dig = s_q[SW-1:7];
    assign s_seg = s_q[6:0];
    assign dec   = seg_decode(s_seg);

    always_comb begin
        enc_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (s_dig[i]) enc_idx = IDX_W'(i);
        end
    end

    always_comb begin
        sync1_d      = {dig_en, seg};
        s_d          = sync1_q;
        // S changes on this edge whenever the first stage disagrees with it
        s_change     = (sync1_q != s_q);
        one_hot      = (s_dig != '0) && ((s_dig & (s_dig - 1'b1)) == '0);
        if (s_change)
            cnt_d = '0;
        else if (cnt_q == CNT_MAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 1'b1;
        cap          = (state_q == ST_WAIT) && !s_change && (cnt_d == CNT_MAX) && one_hot;
        state_d      = state_q;
        case (state_q)
            ST_WAIT: if (cap)      state_d = ST_HOLD;
            ST_HOLD: if (s_change) state_d = ST_WAIT;
            default:               state_d = ST_WAIT;
        endcase
        upd_d        = cap;
        upd_idx_d    = upd_idx_q;
        upd_nibble_d = upd_nibble_q;
        upd_err_d    = upd_err_q;
        if (cap) begin
            upd_idx_d    = enc_idx;
            upd_err_d    = dec[4];
            upd_nibble_d = dec[4] ? 4'h0 : dec[3:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            s_q          <= '0;
            cnt_q        <= '0;
            state_q      <= ST_WAIT;
            upd_q        <= 1'b0;
            upd_idx_q    <= '0;
            upd_nibble_q <= '0;
            upd_err_q    <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            s_q          <= s_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            upd_q        <= upd_d;
            upd_idx_q    <= upd_idx_d;
            upd_nibble_q <= upd_nibble_d;
            upd_err_q    <= upd_err_d;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        seven_segment_reader_digit u_digit (
            .clk        (clk),
            .rst        (rst),
            .clr        (clr),
            .cap        (cap & s_dig[g]),
            .cap_err    (dec[4]),
            .cap_nibble (dec[3:0]),
            .digit      (digits[4*g +: 4]),
            .valid      (digit_valid[g]),
            .err        (digit_err[g])
        );
    end

    assign upd        = upd_q;
    assign upd_idx    = upd_idx_q;
    assign upd_nibble = upd_nibble_q;
    assign upd_err    = upd_err_q;
endmodule

// File: tb/tb_seven_segment_reader.sv
// Scoreboard bench for seven_segment_reader: stimulus queues expected captures,
// a negedge monitor pops and compares each upd strobe.

module tb_seven_segment_reader;
    localparam int STB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  digit_err;
    logic        upd;
    logic [1:0]  upd_idx;
    logic [3:0]  upd_nibble;
    logic        upd_err;

    seven_segment_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(STB)) dut (
        .clk(clk), .rst(rst), .seg(seg), .dig_en(dig_en), .clr(clr),
        .digits(digits), .digit_valid(digit_valid), .digit_err(digit_err),
        .upd(upd), .upd_idx(upd_idx), .upd_nibble(upd_nibble), .upd_err(upd_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  idx;
        logic [3:0]  nib;
        logic        er;
        logic [15:0] digs;
        logic [3:0]  val;
        logic [3:0]  errs;
        int          at;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_digits = '0;
    logic [3:0]  m_valid  = '0;
    logic [3:0]  m_err    = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [3:0] de, input logic [3:0] nib, input bit er,
                        input bit with_clr, input int at);
        exp_t e;
        int   idx = 0;
        for (int i = 0; i < 4; i++) if (de[i]) idx = i;
        if (with_clr) begin
            m_valid = '0;
            m_err   = '0;
        end
        if (er) begin
            m_valid[idx] = 1'b0;
            m_err[idx]   = 1'b1;
        end else begin
            m_digits[idx*4 +: 4] = nib;
            m_valid[idx]         = 1'b1;
            m_err[idx]           = 1'b0;
        end
        e.idx  = 2'(idx);
        e.nib  = er ? 4'h0 : nib;
        e.er   = er;
        e.digs = m_digits;
        e.val  = m_valid;
        e.errs = m_err;
        e.at   = at;
        sb.push_back(e);
    endtask

    // Holds the new input for 'hold' samples; optional clr lands on the capture edge
    task automatic drive(input logic [3:0] de, input logic [6:0] sg, input int hold,
                         input bit exp_cap, input logic [3:0] nib, input bit er,
                         input bit with_clr);
        int c;
        @(posedge clk); #1;
        dig_en = de;
        seg    = sg;
        c      = cyc;
        if (exp_cap) push(de, nib, er, with_clr, c + 2 + STB);
        if (with_clr) begin
            repeat (STB + 1) @(posedge clk);
            #1 clr = 1'b1;
            @(posedge clk);
            #1 clr = 1'b0;
            repeat (hold - STB - 3) @(posedge clk);
        end else begin
            repeat (hold - 1) @(posedge clk);
        end
    endtask

    task automatic drained(input string name);
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && upd) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_upd: got upd=1 idx=%0d at cycle %0d expected no capture",
                         upd_idx, cyc);
            end else begin
                e = sb.pop_front();
                chk("upd_cycle",   cyc,         e.at);
                chk("upd_idx",     upd_idx,     e.idx);
                chk("upd_nibble",  upd_nibble,  e.nib);
                chk("upd_err",     upd_err,     e.er);
                chk("digits",      digits,      e.digs);
                chk("digit_valid", digit_valid, e.val);
                chk("digit_err",   digit_err,   e.errs);
            end
        end
    end

    initial begin
        int r;
        rst    = 1'b1;
        clr    = 1'b0;
        dig_en = 4'b0001;
        seg    = 7'h5B;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_upd",        upd,         0);
        chk("rst_upd_idx",    upd_idx,     0);
        chk("rst_upd_nibble", upd_nibble,  0);
        chk("rst_upd_err",    upd_err,     0);
        chk("rst_digits",     digits,      0);
        chk("rst_valid",      digit_valid, 0);
        chk("rst_err",        digit_err,   0);

        @(posedge clk); #1 rst = 1'b0;
        r = cyc;
        push(4'b0001, 4'h2, 1'b0, 1'b0, r + 2 + STB);
        repeat (12) @(posedge clk);
        #1 chk("first_digit0", digits[3:0], 4'h2);
        drained("drain_reset");

        drive(4'b0000, 7'h00, 5,  0, 4'h0, 0, 0);
        drive(4'b0001, 7'h5B, 10, 1, 4'h2, 0, 0);
        drive(4'b0010, 7'h6D, 10, 1, 4'h5, 0, 0);
        drive(4'b0100, 7'h7F, 10, 1, 4'h8, 0, 0);
        drive(4'b1000, 7'h79, 10, 1, 4'hE, 0, 0);
        #1;
        chk("rt_digits", digits,      16'hE852);
        chk("rt_valid",  digit_valid, 4'hF);
        drained("drain_roundtrip");

        for (int n = 0; n < 16; n++) drive(4'b0100, tbl[n], 10, 1, 4'(n), 0, 0);
        drained("drain_sweep");

        drive(4'b0010, 7'h00, 10, 1, 4'h0, 1, 0);
        #1 chk("inv_digit1_kept", digits[7:4], 4'h5);
        drive(4'b0011, 7'h5B, 20, 0, 4'h0, 0, 0);
        drive(4'b0000, 7'h5B, 20, 0, 4'h0, 0, 0);
        drained("drain_invalid_blank");

        for (int i = 0; i < 10; i++)
            drive(4'b0001, (i % 2 == 0) ? 7'h06 : 7'h0E, 3, 0, 4'h0, 0, 0);
        drive(4'b0001, 7'h06, 110, 1, 4'h1, 0, 0);
        drained("drain_glitch");

        drive(4'b0100, 7'h07, 10, 1, 4'h7, 0, 1);
        #1;
        chk("clr_valid",  digit_valid,  4'b0100);
        chk("clr_err",    digit_err,    4'b0000);
        chk("clr_digit2", digits[11:8], 4'h7);
        drained("drain_clr");

        @(posedge clk); #1;
        dig_en = 4'b1000;
        seg    = 7'h3F;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_upd",        upd,         0);
        chk("mid_upd_idx",    upd_idx,     0);
        chk("mid_upd_nibble", upd_nibble,  0);
        chk("mid_upd_err",    upd_err,     0);
        chk("mid_digits",     digits,      0);
        chk("mid_valid",      digit_valid, 0);
        chk("mid_err",        digit_err,   0);
        m_digits = '0;
        m_valid  = '0;
        m_err    = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        r = cyc;
        push(4'b1000, 4'h0, 1'b0, 1'b0, r + 2 + STB);
        repeat (30) @(posedge clk);
        drained("drain_mid_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
